onehot_stim_gen: RTL and testbench

Self-contained stimulus and utility block combining a free-running binary clock-divider counter, per-bit rising-edge pulses of that counter, a C-library-compatible pseudo-random generator, and a "leave lowest one-hot" isolator. It is used in benches and in datapaths that need derived enables, random values, or lowest-set-bit selection. Everything runs on one clock domain.

---
 rtl/onehot_stim_gen.sv | 78 +++++++
 tb/tb_onehot_stim_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_stim_gen.sv
// onehot_stim_gen: free-running divider counter with per-bit rising-edge
// pulses, a C-library-compatible LCG random source, and a lowest-set-bit
// isolator on a selectable source vector.
module onehot_stim_gen #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             ena,
    input  logic             reseed,
    input  logic [31:0]      seed_val,
    input  logic             oh_src_sel,
    input  logic [WIDTH-1:0] oh_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic [WIDTH-1:0] cnt_rise,
    output logic [15:0]      rnd_out,
    output logic [WIDTH-1:0] oh_out,
    output logic             oh_any
);

    localparam int unsigned RND_W  = 32;
    localparam logic [RND_W-1:0] LCG_MUL  = 32'd1103515245;
    localparam logic [RND_W-1:0] LCG_ADD  = 32'd12345;
    localparam logic [RND_W-1:0] RND_INIT = 32'd1;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_d;
    logic [RND_W-1:0] state;
    logic [RND_W-1:0] state_next;
    logic [WIDTH-1:0] src;

    // Divider counter: advances only when enabled, wraps modulo 2^WIDTH.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (ena) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    // Delayed copy for edge detection; tracks every clock so a held count
    // produces only a single-cycle pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_d <= '0;
        end else begin
            cnt_d <= cnt;
        end
    end

    // LCG next-state: reseed wins over the free-running update.
    always_comb begin
        state_next = state * LCG_MUL + LCG_ADD;
        if (reseed) begin
            state_next = seed_val;
        end
    end

    // Random generator state; reset seed of 1 matches the C library default.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= RND_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Output mapping and the combinational one-hot isolator.
    always_comb begin
        src      = oh_src_sel ? oh_in : cnt;
        oh_out   = src & (~src + WIDTH'(1));
        oh_any   = |src;
        cnt_out  = cnt;
        cnt_rise = cnt & ~cnt_d;
        rnd_out  = {1'b0, state[30:16]};
    end

endmodule

// File: tb/tb_onehot_stim_gen.sv
// Directed self-checking bench for onehot_stim_gen at WIDTH=4.
module tb_onehot_stim_gen;

    localparam int unsigned W = 4;

    logic         clk;
    logic         nrst;
    logic         ena;
    logic         reseed;
    logic [31:0]  seed_val;
    logic         oh_src_sel;
    logic [W-1:0] oh_in;
    logic [W-1:0] cnt_out;
    logic [W-1:0] cnt_rise;
    logic [15:0]  rnd_out;
    logic [W-1:0] oh_out;
    logic         oh_any;

    int n_cmp;
    int n_fail;

    onehot_stim_gen #(.WIDTH(W)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .ena        (ena),
        .reseed     (reseed),
        .seed_val   (seed_val),
        .oh_src_sel (oh_src_sel),
        .oh_in      (oh_in),
        .cnt_out    (cnt_out),
        .cnt_rise   (cnt_rise),
        .rnd_out    (rnd_out),
        .oh_out     (oh_out),
        .oh_any     (oh_any)
    );

    // 10-time-unit clock; rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int exp_rnd [4];
        exp_rnd = '{16838, 5758, 10113, 17515};
        nrst = 1'b0; ena = 1'b0; reseed = 1'b0; seed_val = '0;
        oh_src_sel = 1'b0; oh_in = '0;
        #2;
        n_cmp++;
        if (cnt_out !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %h want %h", cnt_out, 4'd0); end
        n_cmp++;
        if (cnt_rise !== 4'd0) begin n_fail++; $display("FAIL reset_rise got %h want %h", cnt_rise, 4'd0); end
        n_cmp++;
        if (rnd_out !== 16'd0) begin n_fail++; $display("FAIL reset_rnd got %0d want %0d", rnd_out, 0); end
        n_cmp++;
        if (oh_out !== 4'd0 || oh_any !== 1'b0) begin
            n_fail++; $display("FAIL reset_oh got %h/%b want 0/0", oh_out, oh_any);
        end
        #8 nrst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (rnd_out !== 16'(exp_rnd[i])) begin
                n_fail++; $display("FAIL rnd_seq[%0d] got %0d want %0d", i, rnd_out, exp_rnd[i]);
            end
        end
        n_cmp++;
        if (cnt_out !== 4'd0) begin n_fail++; $display("FAIL hold_after_reset got %h want 0", cnt_out); end
    endtask

    task automatic test_count();
        logic [W-1:0] exp_cnt;
        logic [W-1:0] prev_cnt;
        logic [W-1:0] exp_rise;
        prev_cnt = 4'd0;
        ena = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_cnt  = 4'((k + 1) % 16);
            exp_rise = exp_cnt & ~prev_cnt;
            n_cmp++;
            if (cnt_out !== exp_cnt) begin
                n_fail++; $display("FAIL count[%0d] got %h want %h", k, cnt_out, exp_cnt);
            end
            n_cmp++;
            if (cnt_rise !== exp_rise) begin
                n_fail++; $display("FAIL rise[%0d] got %b want %b", k, cnt_rise, exp_rise);
            end
            if (exp_cnt == 4'd8) begin
                n_cmp++;
                if (cnt_rise !== 4'b1000) begin n_fail++; $display("FAIL rise_bit3 got %b want 1000", cnt_rise); end
            end
            if (exp_cnt == 4'd0) begin
                n_cmp++;
                if (cnt_rise !== 4'b0000) begin n_fail++; $display("FAIL rise_wrap got %b want 0000", cnt_rise); end
            end
            prev_cnt = exp_cnt;
        end
    endtask

    task automatic test_ena_toggle();
        logic         ena_seq  [4];
        logic [W-1:0] cnt_seq  [4];
        logic [W-1:0] rise_seq [4];
        logic [W-1:0] last_rise;
        // Count sits at 4 after the 20-cycle run.
        ena_seq  = '{1'b1, 1'b0, 1'b0, 1'b1};
        cnt_seq  = '{4'd5, 4'd5, 4'd5, 4'd6};
        rise_seq = '{4'b0001, 4'b0000, 4'b0000, 4'b0010};
        last_rise = cnt_rise;
        for (int i = 0; i < 4; i++) begin
            ena = ena_seq[i];
            tick();
            n_cmp++;
            if (cnt_out !== cnt_seq[i] || cnt_rise !== rise_seq[i]) begin
                n_fail++;
                $display("FAIL ena_toggle[%0d] got %h/%b want %h/%b", i, cnt_out, cnt_rise, cnt_seq[i], rise_seq[i]);
            end
            n_cmp++;
            if ((last_rise & cnt_rise) !== 4'b0000) begin
                n_fail++; $display("FAIL rise_twice[%0d] got %b after %b want no overlap", i, cnt_rise, last_rise);
            end
            last_rise = cnt_rise;
        end
        ena = 1'b0;
    endtask

    task automatic test_onehot();
        logic [W-1:0] vin  [3];
        logic [W-1:0] vout [3];
        logic         vany [3];
        vin  = '{4'b1100, 4'b0000, 4'b1000};
        vout = '{4'b0100, 4'b0000, 4'b1000};
        vany = '{1'b1, 1'b0, 1'b1};
        oh_src_sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            oh_in = vin[i];
            #1;
            n_cmp++;
            if (oh_out !== vout[i] || oh_any !== vany[i]) begin
                n_fail++;
                $display("FAIL onehot[%0d] got %b/%b want %b/%b", i, oh_out, oh_any, vout[i], vany[i]);
            end
        end
        // Counter source: count is 6 -> lowest set bit is bit 1.
        oh_src_sel = 1'b0;
        #1;
        n_cmp++;
        if (oh_out !== 4'b0010 || oh_any !== 1'b1) begin
            n_fail++; $display("FAIL onehot_cnt got %b/%b want 0010/1", oh_out, oh_any);
        end
    endtask

    task automatic test_reseed();
        int exp_rnd [3];
        exp_rnd = '{0, 16838, 5758};
        reseed = 1'b1; seed_val = 32'd1;
        tick();
        n_cmp++;
        if (rnd_out !== 16'(exp_rnd[0])) begin n_fail++; $display("FAIL reseed_load got %0d want %0d", rnd_out, exp_rnd[0]); end
        tick();
        n_cmp++;
        if (rnd_out !== 16'd0) begin n_fail++; $display("FAIL reseed_hold got %0d want 0", rnd_out); end
        reseed = 1'b0;
        for (int i = 1; i < 3; i++) begin
            tick();
            n_cmp++;
            if (rnd_out !== 16'(exp_rnd[i])) begin
                n_fail++; $display("FAIL reseed_seq[%0d] got %0d want %0d", i, rnd_out, exp_rnd[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        ena = 1'b1;
        tick();
        tick();
        #2;
        nrst = 1'b0;
        #1;
        n_cmp++;
        if (cnt_out !== 4'd0 || cnt_rise !== 4'd0 || rnd_out !== 16'd0 || oh_out !== 4'd0 || oh_any !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got cnt=%h rise=%b rnd=%0d oh=%b any=%b want all zero",
                     cnt_out, cnt_rise, rnd_out, oh_out, oh_any);
        end
        tick();
        n_cmp++;
        if (cnt_out !== 4'd0 || rnd_out !== 16'd0) begin
            n_fail++; $display("FAIL reset_held got cnt=%h rnd=%0d want 0/0", cnt_out, rnd_out);
        end
        #3 nrst = 1'b1;
        tick();
        n_cmp++;
        if (cnt_out !== 4'd1 || cnt_rise !== 4'b0001 || rnd_out !== 16'd16838) begin
            n_fail++;
            $display("FAIL resume got cnt=%h rise=%b rnd=%0d want 1/0001/16838", cnt_out, cnt_rise, rnd_out);
        end
        tick();
        n_cmp++;
        if (cnt_out !== 4'd2 || rnd_out !== 16'd5758) begin
            n_fail++; $display("FAIL resume2 got cnt=%h rnd=%0d want 2/5758", cnt_out, rnd_out);
        end
        ena = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_count();
        test_ena_toggle();
        test_onehot();
        test_reseed();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
